// File: rtl/seq_pkg.sv
// Shared definitions for the sequence transmitter/detector family.
// Holds the state encoding and the default 1011 pattern.
package seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE
    } state_e;

    localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_down_counter.sv
// Unsigned down counter with synchronous load (priority) and decrement.
// Flags when the count equals one so callers can exit before wrapping.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_cnt times with
// optional idle gaps, stalling on x_ready. All outputs are Moore decodes.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = PAT_W'(SEQ_PAT_1011),
    parameter int                 CNT_W   = 8,
    parameter int                 GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             x_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic rem_load, rem_dec, rem_is_one;
    logic gcnt_load, gcnt_dec, gcnt_is_one;

    seq_down_counter #(.W(CNT_W)) u_rem (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rem_load),
        .load_val_i (rep_cnt),
        .dec_i      (rem_dec),
        .is_one_o   (rem_is_one)
    );

    seq_down_counter #(.W(GAP_W)) u_gcnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gcnt_load),
        .load_val_i (gap_q),
        .dec_i      (gcnt_dec),
        .is_one_o   (gcnt_is_one)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        rem_load  = 1'b0;
        rem_dec   = 1'b0;
        gcnt_load = 1'b0;
        gcnt_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rep_cnt != '0) begin
                        rem_load = 1'b1;
                        gap_d    = gap_len;
                        idx_d    = IDX_LAST;
                        state_d  = S_SEND;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (x_ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (rem_is_one) begin
                        state_d = S_DONE;
                    end else begin
                        rem_dec = 1'b1;
                        idx_d   = IDX_LAST;
                        // A non-zero gap parks in GAP; the index is reloaded again on exit.
                        if (gap_q != '0) begin
                            gcnt_load = 1'b1;
                            state_d   = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                gcnt_dec = 1'b1;
                if (gcnt_is_one) begin
                    idx_d   = IDX_LAST;
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    assign x_valid = (state_q == S_SEND);
    assign x_out   = x_valid & PATTERN[idx_q];
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and randomized bench for seq_pattern_tx against a queue-based
// model of the expected per-cycle output stream.
module tb_seq_pattern_tx;

    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rep_cnt;
    logic [3:0] gap_len;
    logic       x_ready;
    logic       x_out;
    logic       x_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int stream[$];
    logic [PW-1:0] pat_v;

    seq_pattern_tx dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rep_cnt (rep_cnt),
        .gap_len (gap_len),
        .x_ready (x_ready),
        .x_out   (x_out),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(x_valid), 0);
        chk({tag, "_xout"},  32'(x_out),   0);
        chk({tag, "_busy"},  32'(busy),    0);
        chk({tag, "_done"},  32'(done),    0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall stall_len cycles on bit stall_at
    task automatic run_xfer(input int rep, input int gap, input int mode,
                            input int stall_at, input int stall_len, input bit poke);
        int  items[$];
        int  cyc = 0;
        int  stalls = 0;
        int  xfers = 0;
        bit  poked = 0;
        bit  got_done = 0;
        bit  rdy;
        int  exp_cyc;
        stream.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = PW - 1; b >= 0; b--) items.push_back(int'(pat_v[b]));
            if (r < rep - 1) for (int g = 0; g < gap; g++) items.push_back(2);
        end
        @(negedge clk);
        start = 1'b1; rep_cnt = 8'(rep); gap_len = 4'(gap); x_ready = 1'b1;
        @(posedge clk);
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                rep_cnt = 8'($urandom);
                gap_len = 4'($urandom);
            end
            if (items.size() == 0) begin
                chk("done_pulse", 32'(done), 1);
                chk("done_busy",  32'(busy), 1);
                chk("done_valid", 32'(x_valid), 0);
                got_done = 1;
                break;
            end
            if (items[0] == 2) begin
                chk("gap_valid", 32'(x_valid), 0);
                chk("gap_xout",  32'(x_out), 0);
                chk("gap_busy",  32'(busy), 1);
                chk("gap_done",  32'(done), 0);
                void'(items.pop_front());
                if (poke && !poked) begin
                    start = 1'b1;
                    poked = 1;
                end
                x_ready = 1'($urandom_range(0, 1));
            end else begin
                chk("bit_valid", 32'(x_valid), 1);
                chk("bit_xout",  32'(x_out), 32'(items[0]));
                chk("bit_busy",  32'(busy), 1);
                chk("bit_done",  32'(done), 0);
                case (mode)
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    2:       rdy = !(xfers == stall_at && stalls < stall_len);
                    default: rdy = 1'b1;
                endcase
                x_ready = rdy;
                if (rdy) begin
                    stream.push_back(items[0]);
                    void'(items.pop_front());
                    xfers++;
                end else begin
                    stalls++;
                end
            end
        end
        if (!got_done) chk("timeout", 0, 1);
        exp_cyc = rep * PW + ((rep > 0) ? (rep - 1) * gap : 0) + 1 + stalls;
        chk("latency", 32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        start = 1'b0;
        x_ready = 1'b1;
        chk_idle("after_done");
    endtask

    initial begin
        int hits;
        int r, g;
        pat_v   = 4'b1011;
        reset   = 1'b1;
        start   = 1'b0;
        rep_cnt = '0;
        gap_len = '0;
        x_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        start = 1'b1; rep_cnt = 8'd3;
        @(negedge clk);
        chk_idle("reset_over_start");
        reset = 1'b0;
        start = 1'b0;

        // reset mid-transfer on the 3rd bit
        @(negedge clk);
        start = 1'b1; rep_cnt = 8'd5; gap_len = 4'd0; x_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("mid_b1", 32'(x_out), 1);
        @(negedge clk);
        chk("mid_b2", 32'(x_out), 0);
        @(negedge clk);
        chk("mid_b3", 32'(x_out), 1);
        chk("mid_b3v", 32'(x_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("mid_reset");
        @(negedge clk);
        chk_idle("mid_reset_nodone");

        run_xfer(2, 1, 0, 0, 0, 0);
        run_xfer(0, 5, 0, 0, 0, 0);
        run_xfer(1, 0, 0, 0, 0, 0);

        run_xfer(3, 0, 0, 0, 0, 0);
        hits = 0;
        for (int i = 0; i + 3 < stream.size(); i++)
            if (stream[i] == 1 && stream[i+1] == 0 && stream[i+2] == 1 && stream[i+3] == 1) hits++;
        chk("loop_hits", 32'(hits), 3);
        chk("loop_len", 32'(stream.size()), 12);

        run_xfer(2, 3, 0, 0, 0, 1);
        run_xfer(1, 0, 2, 1, 2, 0);

        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 4);
            g = $urandom_range(0, 3);
            run_xfer(r, g, 1, 0, 0, (k % 2) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the `x` input of the sequence-detector family. It emits a fixed `PAT_W`-bit pattern (default 1011) MSB-first, a programmable number of times, with an optional idle gap between repetitions. A valid/ready handshake stalls it against a slow sink. It serves as the stimulus source for detector loopback tests and as the transmit end of pattern-framed serial links.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits (2..16).
- `PATTERN`, 4'b1011: bits sent MSB (`PATTERN[PAT_W-1]`) first.
- `CNT_W`, 8: width of the repetition count.
- `GAP_W`, 4: width of the gap length.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `rep_cnt` in `CNT_W`: number of pattern repetitions. Latched on an accepted `start`.
- `gap_len` in `GAP_W`: idle cycles inserted between repetitions. Latched on an accepted `start`.
- `x_ready` in 1: sink accepts the current bit.
- `x_out` out 1: serial bit.
- `x_valid` out 1: `x_out` carries a pattern bit.
- `busy` out 1: transfer in progress (state is not IDLE).
- `done` out 1: one-cycle pulse at the end of a transfer.

## Operation
- The FSM has four states: IDLE, SEND, GAP, DONE.
- Outputs are Moore outputs. They decode from registered state, bit index, and counters only, with no combinational path from inputs.
- **IDLE:**
  - Outputs: `x_out`=0, `x_valid`=0, `busy`=0.
  - `start`=1 and `rep_cnt`≠0: latch `rep_cnt` into `rem`, latch `gap_len` into `gap_q`, set `idx`=`PAT_W`-1, go to SEND.
  - `start`=1 and `rep_cnt`=0: go to DONE. No bits are sent.
- **SEND:**
  - Outputs: `x_valid`=1, `x_out`=`PATTERN[idx]`.
  - A bit is transferred when `x_valid` and `x_ready` are both 1 at a rising edge.
  - While `x_ready`=0: hold `idx` and all outputs. There is no timeout.
  - Transfer with `idx`>0: decrement `idx`.
  - Transfer with `idx`=0 and `rem`=1: go to DONE.
  - Transfer with `idx`=0, `rem`>1, and `gap_q`=0: decrement `rem`, set `idx`=`PAT_W`-1, stay in SEND. Repetitions are back-to-back.
  - Transfer with `idx`=0, `rem`>1, and `gap_q`>0: decrement `rem`, load `gcnt`=`gap_q`, go to GAP.
- **GAP:**
  - Outputs: `x_valid`=0, `x_out`=0.
  - Decrement `gcnt` every cycle, ignoring `x_ready`.
  - At `gcnt`=1: set `idx`=`PAT_W`-1 and go to SEND.
- **DONE:**
  - Outputs: `done`=1, `busy`=1, `x_valid`=0.
  - Next cycle: go to IDLE unconditionally.
- `start` outside IDLE is ignored. `rep_cnt` and `gap_len` changes after latching have no effect on the transfer in progress.
- Counter arithmetic is unsigned. `rem` never wraps because SEND exits at `rem`=1, and `gcnt` never wraps because GAP exits at `gcnt`=1.

## Timing
- Reset values: state=IDLE, `x_out`=0, `x_valid`=0, `busy`=0, `done`=0. All counters are 0.
- `reset` asserted mid-transfer: IDLE on the next edge. No `done` pulse is produced and the partial pattern is abandoned.
- `reset` has priority over `start` in the same cycle.
- `start` accepted at edge T: first bit on `x_out` with `x_valid`=1 during cycle T+1.
- Cycles from accepted `start` to `done`, with `x_ready` held at 1: `rep_cnt`·`PAT_W` + (`rep_cnt`-1)·`gap_len` cycles of SEND/GAP, then one DONE cycle.
- `rep_cnt`=0: `done` is high during cycle T+1.
- Earliest next `start` is the cycle after DONE, i.e. back in IDLE.

## Structure
- Shared package `seq_pkg`:
  - state encoding localparams (IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11);
  - default pattern constant `SEQ_PAT_1011` = 4'b1011, also used by the detector benches.
- Sub-module `seq_down_counter` (parameterised width, synchronous load/decrement, `is_one` flag), instantiated for `rem` and `gcnt`.
- FSM, bit index, and output decode live in the top module.

## Test plan
- **Reset mid-transfer:** start `rep_cnt`=5, assert `reset` on the 3rd bit -> next cycle all outputs 0, no `done`; a later start runs normally.
- **Zero repetitions:** `rep_cnt`=0 -> `x_valid` never high; `done`=1 exactly one cycle after `start`; `busy` high for that one cycle only.
- **Single pattern:** `rep_cnt`=1, `gap_len`=0, `x_ready`=1 -> `x_out`=1,0,1,1 in cycles T+1..T+4, `x_valid` high for those 4 cycles, `done` at T+5.
- **Loopback to detector:** `rep_cnt`=3, `gap_len`=0 into the 1011 Mealy detector -> stream 101110111011, detector `z` pulses exactly 3 times, `done` at T+13.
- **Gap insertion:** `rep_cnt`=2, `gap_len`=3 -> 4 bits, 3 cycles of `x_valid`=0, 4 bits, `done` at T+12; `start` pulsed mid-gap is ignored.
- **Backpressure:** `rep_cnt`=1, `x_ready` low for 2 cycles on the 2nd bit -> `x_out`=0 held with `x_valid`=1, sequence 1011 intact, `done` at T+7.
